// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and the default bit period.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, framing-error detection and break recovery.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_serial,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_frame_err,
  output logic       o_rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  logic           rx_sync;
  uart_rx_state_e state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     idx_q;
  logic [7:0]     shift_q;
  logic [7:0]     byte_q;
  logic           dv_q;
  logic           ferr_q;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .async_i (i_rx_serial),
    .sync_o  (rx_sync)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_sync) state_q <= ST_START;
        end
        ST_START: begin
          // Re-check the start bit at its centre; a short low pulse is a glitch.
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (!rx_sync) state_q <= ST_DATA;
            else          state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_sync;
            if (idx_q == 3'd7) state_q <= ST_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rx_sync) begin
              byte_q  <= shift_q;
              dv_q    <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_RECOVER;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RECOVER: begin
          // Hold here through a break so it reports only one framing error.
          if (rx_sync) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_rx_dv        = dv_q;
  assign o_rx_byte      = byte_q;
  assign o_rx_frame_err = ferr_q;
  assign o_rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at the default 217 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 217;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_ferr;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  int dv_cnt    = 0;
  int ferr_cnt  = 0;
  int both_cnt  = 0;
  int wide_cnt  = 0;
  int chg_cnt   = 0;
  logic       prev_dv   = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_rx_serial    (rx),
    .o_rx_dv        (rx_dv),
    .o_rx_byte      (rx_byte),
    .o_rx_frame_err (rx_ferr),
    .o_rx_busy      (rx_busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_dv) begin
        dv_cnt = dv_cnt + 1;
        got_q.push_back(rx_byte);
      end
      if (rx_ferr) ferr_cnt = ferr_cnt + 1;
      if (rx_dv && rx_ferr) both_cnt = both_cnt + 1;
      if ((rx_dv && prev_dv) || (rx_ferr && prev_ferr)) wide_cnt = wide_cnt + 1;
      if ((rx_byte !== prev_byte) && !rx_dv) chg_cnt = chg_cnt + 1;
    end
    prev_dv   = rx_dv;
    prev_ferr = rx_ferr;
    prev_byte = rx_byte;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle_cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_level);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_level);
  endtask

  // Scoreboard: compare the next received byte against the next expected byte
  task automatic check_next(input string tag);
    logic [7:0] e;
    logic [7:0] g;
    e = exp_q.pop_front();
    if (got_q.size() > 0) g = got_q.pop_front();
    else                  g = 8'hxx;
    check(tag, {24'h0, g}, {24'h0, e});
  endtask

  initial begin
    int dv_base;
    int ferr_base;

    rst_n = 1'b0;
    rx    = 1'b1;
    idle_cycles(5);
    check("reset_byte", {24'h0, rx_byte}, 32'h00);
    check("reset_dv",   {31'h0, rx_dv},   32'h0);
    check("reset_ferr", {31'h0, rx_ferr}, 32'h0);
    check("reset_busy", {31'h0, rx_busy}, 32'h0);
    rst_n = 1'b1;
    idle_cycles(10);

    // Single good frame
    exp_q.push_back(8'h37);
    send_frame(8'h37, 1'b1);
    idle_cycles(10);
    check("f37_dv_count",   dv_cnt,   32'd1);
    check("f37_byte",       {24'h0, rx_byte}, 32'h37);
    check_next("f37_rx");
    check("f37_ferr_count", ferr_cnt, 32'd0);
    check("f37_busy_idle",  {31'h0, rx_busy}, 32'h0);

    // 50-cycle low glitch: start check falls at sync(2) + detect(1) + half bit(108)
    dv_base   = dv_cnt;
    ferr_base = ferr_cnt;
    rx = 1'b0;
    idle_cycles(50);
    check("glitch_busy_high", {31'h0, rx_busy}, 32'h1);
    rx = 1'b1;
    idle_cycles(50);
    check("glitch_busy_mid", {31'h0, rx_busy}, 32'h1);
    idle_cycles(12);
    check("glitch_busy_low", {31'h0, rx_busy}, 32'h0);
    check("glitch_no_dv",   dv_cnt,   dv_base);
    check("glitch_no_ferr", ferr_cnt, ferr_base);
    idle_cycles(CPB);

    // Framing error followed by a held break, then a good frame
    dv_base = dv_cnt;
    send_frame(8'hA5, 1'b0);
    rx = 1'b0;
    idle_cycles(5 * CPB);
    check("brk_ferr_count", ferr_cnt, 32'd1);
    check("brk_no_dv",      dv_cnt,   dv_base);
    check("brk_byte_held",  {24'h0, rx_byte}, 32'h37);
    check("brk_busy",       {31'h0, rx_busy}, 32'h1);
    rx = 1'b1;
    idle_cycles(2 * CPB);
    check("brk_recovered",  {31'h0, rx_busy}, 32'h0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle_cycles(10);
    check("f5a_dv_count", dv_cnt, dv_base + 1);
    check("f5a_byte",     {24'h0, rx_byte}, 32'h5A);
    check_next("f5a_rx");
    check("f5a_ferr_count", ferr_cnt, 32'd1);

    // Back-to-back frames, no idle gap
    dv_base = dv_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_cycles(10);
    check("b2b_dv_count", dv_cnt, dv_base + 2);
    check_next("b2b_first");
    check_next("b2b_second");
    check("b2b_byte", {24'h0, rx_byte}, 32'hFF);

    // Reset in the middle of data bit 4 of 0xC3
    dv_base = dv_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(((8'hC3 >> i) & 8'h01) != 0);
    rx = 1'b0;
    idle_cycles(CPB / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    idle_cycles(3);
    check("rst_mid_busy", {31'h0, rx_busy}, 32'h0);
    check("rst_mid_byte", {24'h0, rx_byte}, 32'h00);
    rst_n = 1'b1;
    idle_cycles(CPB);
    check("rst_no_dv", dv_cnt, dv_base);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle_cycles(10);
    check("f81_dv_count", dv_cnt, dv_base + 1);
    check("f81_byte",     {24'h0, rx_byte}, 32'h81);
    check_next("f81_rx");

    // Global pulse/hold properties over the whole run
    check("never_dv_and_ferr", both_cnt, 32'd0);
    check("pulses_one_cycle",  wide_cnt, 32'd0);
    check("byte_only_with_dv", chg_cnt,  32'd0);
    check("ferr_total",        ferr_cnt, 32'd1);
    check("no_extra_bytes",    got_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
